// File: rtl/clk_meas_pkg.sv
// Shared types and constants for the clock frequency meter and its edge detector.
package clk_meas_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    STALL   = 2'd3
  } meas_state_t;

  localparam int SYNC_STAGES = 2;
  localparam int CNT_W_DEF   = 32;

endpackage

// File: rtl/clk_freq_meter_if.sv
// Control/result bundle of the clock frequency meter: enable in, measurements out.
interface clk_freq_meter_if
  import clk_meas_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             enable;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             timeout;

  modport master (output enable, input period, high_time, meas_valid, timeout);
  modport slave  (input enable, output period, high_time, meas_valid, timeout);
endinterface

// File: rtl/sync_edge_det.sv
// Multi-stage synchroniser plus history flop producing one-cycle rise/fall pulses
// for an asynchronous input (measured clocks, buttons, ...).
module sync_edge_det
  import clk_meas_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~hist_q;
  assign fall = ~sync_q[STAGES-1] & hist_q;
endmodule

// File: rtl/clk_freq_meter.sv
// Measures period and high time of a slow asynchronous clock in reference cycles.
// Optional stall watchdog enabled by defining CLK_FREQ_METER_TIMEOUT_EN.
//
//   state   | meaning
//   IDLE    | disabled, counter cleared
//   ARM     | waiting for the first rising edge
//   MEASURE | counting; fall latches high time, rise publishes results
//   STALL   | watchdog fired, waiting for the input to restart
module clk_freq_meter
  import clk_meas_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TIMEOUT_CYC = 100_000_000
) (
  input logic            clk_100MHz,
  input logic            rst_n,
  input logic            meas_clk,
  clk_freq_meter_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [63:0]      TO_LIM  = 64'(TIMEOUT_CYC) - 64'd1;

  meas_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] hi_lat;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_q;
  logic             valid_q;
  logic             rise;
  logic             fall;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk_100MHz),
    .rst_n(rst_n),
    .din  (meas_clk),
    .rise (rise),
    .fall (fall)
  );

  // Saturating increment shared by the counter and both published results.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

`ifdef CLK_FREQ_METER_TIMEOUT_EN
  logic timeout_q;
  assign bus.timeout = timeout_q;
`else
  logic unused_to;
  assign unused_to   = ^TO_LIM;
  assign bus.timeout = 1'b0;
`endif

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      hi_lat    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
`ifdef CLK_FREQ_METER_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      if (!bus.enable) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            cnt   <= '0;
            state <= ARM;
          end
          ARM: begin
            if (rise) begin
              cnt    <= '0;
              hi_lat <= '0;
              state  <= MEASURE;
            end
          end
          MEASURE: begin
            if (rise) begin
              period_q  <= cnt_inc;
              high_q    <= hi_lat;
              valid_q   <= 1'b1;
              cnt       <= '0;
              // cleared so a missing fall reads back as zero high time
              hi_lat    <= '0;
`ifdef CLK_FREQ_METER_TIMEOUT_EN
              timeout_q <= 1'b0;
`endif
            end else begin
              if (fall) hi_lat <= cnt_inc;
              cnt <= cnt_inc;
`ifdef CLK_FREQ_METER_TIMEOUT_EN
              if (64'(cnt) == TO_LIM) begin
                timeout_q <= 1'b1;
                state     <= STALL;
              end
`endif
            end
          end
`ifdef CLK_FREQ_METER_TIMEOUT_EN
          STALL: begin
            // timeout stays flagged until a full period has been measured again
            if (rise) begin
              cnt    <= '0;
              hi_lat <= '0;
              state  <= MEASURE;
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.period     = period_q;
  assign bus.high_time  = high_q;
  assign bus.meas_valid = valid_q;
endmodule

// File: tb/tb_clk_freq_meter.sv
// Self-checking bench: a 32-bit and an 8-bit meter share one measured clock;
// expected results are queued at each input rising edge and popped on meas_valid.
module tb_clk_freq_meter;
  import clk_meas_pkg::*;

  typedef struct {
    int p;
    int h;
    int tol;
  } exp_t;

  logic clk_100MHz = 1'b0;
  logic rst_n;
  logic meas_clk;

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  exp_t q32[$];
  exp_t q8[$];
  exp_t e32;
  exp_t e8;
  bit   en_m;
  bit   primed32;
  bit   primed8;
  int   last_hi;
  int   last_lo;
  int   last_p32;
  int   last_p8;

  clk_freq_meter_if #(.CNT_W(32)) if32();
  clk_freq_meter_if #(.CNT_W(8))  if8();

  clk_freq_meter #(.CNT_W(32), .TIMEOUT_CYC(500)) u_dut (
    .clk_100MHz(clk_100MHz),
    .rst_n     (rst_n),
    .meas_clk  (meas_clk),
    .bus       (if32)
  );

  clk_freq_meter #(.CNT_W(8), .TIMEOUT_CYC(500)) u_dut8 (
    .clk_100MHz(clk_100MHz),
    .rst_n     (rst_n),
    .meas_clk  (meas_clk),
    .bus       (if8)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  // 32-bit scoreboard
  always @(negedge clk_100MHz) begin
    if (rst_n && if32.meas_valid === 1'b1) begin
      if (q32.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_valid32: got valid period=%0d required no valid", if32.period);
      end else begin
        e32 = q32.pop_front();
        total_cnt++;
        if (int'(if32.period) - e32.p > e32.tol || e32.p - int'(if32.period) > e32.tol)
          $display("FAIL period32: got %0d required %0d+-%0d", if32.period, e32.p, e32.tol);
        else pass_cnt++;
        total_cnt++;
        if (int'(if32.high_time) - e32.h > 1 || e32.h - int'(if32.high_time) > 1)
          $display("FAIL high32: got %0d required %0d+-1", if32.high_time, e32.h);
        else pass_cnt++;
      end
    end
  end

  // 8-bit scoreboard
  always @(negedge clk_100MHz) begin
    if (rst_n && if8.meas_valid === 1'b1) begin
      if (q8.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_valid8: got valid period=%0d required no valid", if8.period);
      end else begin
        e8 = q8.pop_front();
        total_cnt++;
        if (int'(if8.period) - e8.p > e8.tol || e8.p - int'(if8.period) > e8.tol)
          $display("FAIL period8: got %0d required %0d+-%0d", if8.period, e8.p, e8.tol);
        else pass_cnt++;
        total_cnt++;
        if (int'(if8.high_time) - e8.h > 1 || e8.h - int'(if8.high_time) > 1)
          $display("FAIL high8: got %0d required %0d+-1", if8.high_time, e8.h);
        else pass_cnt++;
      end
    end
  end

  task automatic set_en(input bit v);
    if32.enable = v;
    if8.enable  = v;
    en_m        = v;
  endtask

  // model of one input rising edge: closes the previous period if armed
  task automatic push_rise();
    int p;
    int p8;
    exp_t e;
    p  = (last_hi + last_lo) / 10;
    p8 = (p > 255) ? 255 : p;
    if (primed32) begin
      e.p = p;  e.h = last_hi / 10; e.tol = 1;
      q32.push_back(e);
      last_p32 = p;
    end
    if (primed8) begin
      e.p = p8; e.h = last_hi / 10; e.tol = (p > 255) ? 0 : 1;
      q8.push_back(e);
      last_p8 = p8;
    end
    if (en_m) begin
      primed32 = 1'b1;
      primed8  = 1'b1;
    end
  endtask

  task automatic meas_cycle(input int hi_ns, input int lo_ns);
    meas_clk = 1'b1;
    push_rise();
    last_hi = hi_ns;
    last_lo = lo_ns;
    #(hi_ns);
    meas_clk = 1'b0;
    #(lo_ns);
  endtask

  task automatic idle_low(input int ns);
    #(ns);
    last_lo += ns;
  endtask

  task automatic check_drained(input string name);
    total_cnt++;
    if (q32.size() != 0) $display("FAIL %s_drain32: got %0d pending required 0", name, q32.size());
    else pass_cnt++;
    total_cnt++;
    if (q8.size() != 0) $display("FAIL %s_drain8: got %0d pending required 0", name, q8.size());
    else pass_cnt++;
  endtask

  task automatic test_reset();
    #23;
    total_cnt++;
    if (if32.period !== 32'd0) $display("FAIL rst_period: got %0d required 0", if32.period);
    else pass_cnt++;
    total_cnt++;
    if (if32.high_time !== 32'd0) $display("FAIL rst_high: got %0d required 0", if32.high_time);
    else pass_cnt++;
    total_cnt++;
    if (if32.meas_valid !== 1'b0) $display("FAIL rst_valid: got %b required 0", if32.meas_valid);
    else pass_cnt++;
    total_cnt++;
    if (if32.timeout !== 1'b0) $display("FAIL rst_timeout: got %b required 0", if32.timeout);
    else pass_cnt++;
    total_cnt++;
    if (if8.period !== 8'd0) $display("FAIL rst_period8: got %0d required 0", if8.period);
    else pass_cnt++;
    @(negedge clk_100MHz);
    rst_n = 1'b1;
    // place measured-clock edges 2 units before reference rising edges
    @(posedge clk_100MHz);
    #8;
  endtask

  task automatic test_basic();
    set_en(1'b1);
    idle_low(100);
    for (int i = 0; i < 6; i++) meas_cycle(500, 500);
    idle_low(100);
    check_drained("basic");
  endtask

  task automatic test_duty();
    for (int i = 0; i < 5; i++) meas_cycle(300, 700);
    idle_low(100);
    check_drained("duty");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) meas_cycle(1500, 1500);
    idle_low(100);
    check_drained("sat");
  endtask

  task automatic test_timeout();
    int n;
    bit seen;
    meas_cycle(500, 500);
    meas_cycle(500, 500);
    meas_clk = 1'b1;
    push_rise();
    last_hi = 500;
    last_lo = 7000;
    n    = 0;
    seen = 1'b0;
    fork
      begin
        #500;
        meas_clk = 1'b0;
        #7000;
      end
      begin
        while (n < 600 && !seen) begin
          @(negedge clk_100MHz);
          n++;
          if (if32.timeout === 1'b1) seen = 1'b1;
        end
      end
    join
`ifdef CLK_FREQ_METER_TIMEOUT_EN
    // 500 counted cycles plus 2-3 cycles of synchroniser latency from the pin edge
    total_cnt++;
    if (!seen || n < 501 || n > 504)
      $display("FAIL timeout_delay: got seen=%0d after %0d cycles required 501..504", seen, n);
    else pass_cnt++;
    total_cnt++;
    if (if32.timeout !== 1'b1) $display("FAIL timeout_sticky: got %b required 1", if32.timeout);
    else pass_cnt++;
    primed32 = 1'b0;
`else
    total_cnt++;
    if (seen) $display("FAIL timeout_tied: got 1 after %0d cycles required 0", n);
    else pass_cnt++;
`endif
    total_cnt++;
    if (if8.timeout !== 1'b0) $display("FAIL timeout8: got %b required 0", if8.timeout);
    else pass_cnt++;
    meas_cycle(500, 500);
    meas_cycle(500, 500);
    idle_low(100);
    total_cnt++;
    if (if32.timeout !== 1'b0) $display("FAIL timeout_clear: got %b required 0", if32.timeout);
    else pass_cnt++;
    check_drained("timeout");
  endtask

  task automatic test_enable();
    int nval;
    nval = 0;
    set_en(1'b0);
    primed32 = 1'b0;
    primed8  = 1'b0;
    fork
      begin
        for (int i = 0; i < 3; i++) meas_cycle(500, 500);
      end
      begin
        repeat (300) begin
          @(negedge clk_100MHz);
          if (if32.meas_valid !== 1'b0 || if8.meas_valid !== 1'b0) nval++;
        end
      end
    join
    total_cnt++;
    if (nval != 0) $display("FAIL en_valid: got %0d strobes required 0", nval);
    else pass_cnt++;
    total_cnt++;
    if (int'(if32.period) - last_p32 > 1 || last_p32 - int'(if32.period) > 1)
      $display("FAIL en_hold32: got %0d required %0d+-1", if32.period, last_p32);
    else pass_cnt++;
    total_cnt++;
    if (int'(if8.period) - last_p8 > 1 || last_p8 - int'(if8.period) > 1)
      $display("FAIL en_hold8: got %0d required %0d+-1", if8.period, last_p8);
    else pass_cnt++;
    set_en(1'b1);
    idle_low(100);
    for (int i = 0; i < 3; i++) meas_cycle(500, 500);
    idle_low(100);
    check_drained("enable");
  endtask

  task automatic test_reset_mid();
    meas_cycle(500, 500);
    meas_cycle(500, 500);
    meas_clk = 1'b1;
    push_rise();
    last_hi = 500;
    last_lo = 500;
    #200;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (if32.period !== 32'd0) $display("FAIL mid_rst_period: got %0d required 0", if32.period);
    else pass_cnt++;
    total_cnt++;
    if (if32.high_time !== 32'd0) $display("FAIL mid_rst_high: got %0d required 0", if32.high_time);
    else pass_cnt++;
    total_cnt++;
    if (if32.meas_valid !== 1'b0 || if32.timeout !== 1'b0)
      $display("FAIL mid_rst_flags: got valid=%b timeout=%b required 0/0", if32.meas_valid, if32.timeout);
    else pass_cnt++;
    total_cnt++;
    if (if8.period !== 8'd0) $display("FAIL mid_rst_period8: got %0d required 0", if8.period);
    else pass_cnt++;
    primed32 = 1'b0;
    primed8  = 1'b0;
    #299;
    meas_clk = 1'b0;
    #100;
    rst_n = 1'b1;
    #400;
    for (int i = 0; i < 3; i++) meas_cycle(500, 500);
    idle_low(100);
    check_drained("reset_mid");
  endtask

  initial begin
    rst_n    = 1'b0;
    meas_clk = 1'b0;
    set_en(1'b0);
    primed32 = 1'b0;
    primed8  = 1'b0;
    last_hi  = 0;
    last_lo  = 0;
    last_p32 = 0;
    last_p8  = 0;
    test_reset();
    test_basic();
    test_duty();
    test_saturation();
    test_timeout();
    test_enable();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no completion required finish before 500000");
    $fatal(1, "bench did not complete");
  end
endmodule
